// File: rtl/ultrasonic_echo_emulator_if.sv
// Trig/echo link between the sensor block (master) and the echo emulator (slave).
interface ultrasonic_echo_emulator_if;
    logic        trig;
    logic [7:0]  dist_in;
    logic        echo;
    logic        busy;
    logic        trig_err;
    logic [15:0] meas_cnt;

    modport master (output trig, dist_in, input echo, busy, trig_err, meas_cnt);
    modport slave  (input trig, dist_in, output echo, busy, trig_err, meas_cnt);
endinterface

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04 target emulator: answers an accepted trig pulse with an echo whose width encodes dist_in inches.
// Echo rises 2+BURST_CYCLES after the trig fall is sampled. Optional feature macro: ECHO_JITTER_EN.
// No backpressure: trig edges outside IDLE/TRIG_HI are ignored.
module ultrasonic_echo_emulator #(
    parameter int CLK_HZ          = 12_000_000,
    parameter int TRIG_MIN_CYCLES = CLK_HZ / 100_000,
    parameter int BURST_CYCLES    = CLK_HZ / 5_000,
    parameter int CYC_PER_INCH    = CLK_HZ / 1_000_000 * 148,
    parameter int MAX_INCHES      = 157,
    parameter int TIMEOUT_CYCLES  = CLK_HZ / 1_000 * 38,
    parameter int HOLDOFF_CYCLES  = CLK_HZ / 100,
    parameter int CNT_W           = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    ultrasonic_echo_emulator_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, TRIG_HI, DELAY, ECHO, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] TRIG_MIN   = CNT_W'(TRIG_MIN_CYCLES);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_W  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CPI        = CNT_W'(CYC_PER_INCH);
    localparam logic [7:0]       MAX_IN     = 8'(MAX_INCHES);

    state_t           state;
    logic             trig_m, trig_s, trig_q;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       dist_lat;
    logic [CNT_W-1:0] base_w, echo_w, echo_last;
    logic             accept;

    assign base_w    = (dist_lat != 8'd0 && dist_lat <= MAX_IN) ? CNT_W'(dist_lat) * CPI : TIMEOUT_W;
    assign echo_last = echo_w - CNT_W'(1);
    assign accept    = (state == TRIG_HI) && !trig_s && (cnt >= TRIG_MIN);

`ifdef ECHO_JITTER_EN
    logic [15:0] lfsr;
    logic [3:0]  jit_lat;

    // Galois form, taps 16,14,13,11; stepped once per accepted measurement.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr    <= 16'hACE1;
            jit_lat <= 4'd0;
        end else if (accept) begin
            jit_lat <= lfsr[3:0];
            lfsr    <= {1'b0, lfsr[15:1]} ^ ({16{lfsr[0]}} & 16'hB400);
        end
    end

    assign echo_w = base_w + CNT_W'(jit_lat);
`else
    assign echo_w = base_w;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            trig_m       <= 1'b0;
            trig_s       <= 1'b0;
            trig_q       <= 1'b0;
            cnt          <= '0;
            dist_lat     <= 8'd0;
            bus.echo     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.trig_err <= 1'b0;
            bus.meas_cnt <= 16'd0;
        end else begin
            trig_m       <= bus.trig;
            trig_s       <= trig_m;
            trig_q       <= trig_s;
            bus.trig_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Only a genuine rise counts: trig_s left high from HOLDOFF is ignored.
                    if (trig_s && !trig_q) begin
                        state    <= TRIG_HI;
                        cnt      <= CNT_W'(1);
                        bus.busy <= 1'b1;
                    end
                end
                TRIG_HI: begin
                    if (trig_s) begin
                        if (cnt < TRIG_MIN) cnt <= cnt + CNT_W'(1);
                    end else if (accept) begin
                        dist_lat     <= bus.dist_in;
                        bus.meas_cnt <= bus.meas_cnt + 16'd1;
                        state        <= DELAY;
                        cnt          <= '0;
                    end else begin
                        bus.trig_err <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= IDLE;
                        cnt          <= '0;
                    end
                end
                DELAY: begin
                    if (cnt == BURST_LAST) begin
                        state    <= ECHO;
                        bus.echo <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ECHO: begin
                    if (cnt == echo_last) begin
                        state    <= HOLDOFF;
                        bus.echo <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.echo <= 1'b0;
                    bus.busy <= 1'b0;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Randomized bench for ultrasonic_echo_emulator with scaled-down timing parameters.
module tb_ultrasonic_echo_emulator;

    localparam int TMIN    = 8;
    localparam int BURST   = 20;
    localparam int CPI     = 3;
    localparam int MAXI    = 157;
    localparam int TIMEOUT = 600;
    localparam int HOLD    = 100;

    logic clk;
    logic reset;
    ultrasonic_echo_emulator_if bus ();

    ultrasonic_echo_emulator #(
        .CLK_HZ(12_000_000), .TRIG_MIN_CYCLES(TMIN), .BURST_CYCLES(BURST), .CYC_PER_INCH(CPI),
        .MAX_INCHES(MAXI), .TIMEOUT_CYCLES(TIMEOUT), .HOLDOFF_CYCLES(HOLD), .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_meas = 0;
    int n_rise = 0, n_fall = 0, n_err = 0;
    int rise_cyc = 0, fall_cyc = 0, err_cyc = 0;
    bit echo_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Edge log of the DUT outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.echo && !echo_prev) begin rise_cyc = cyc; n_rise++; end
        if (!bus.echo && echo_prev) begin fall_cyc = cyc; n_fall++; end
        echo_prev = bus.echo;
        if (bus.trig_err) begin err_cyc = cyc; n_err++; end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int exp_width(input int d);
        return (d >= 1 && d <= MAXI) ? d * CPI : TIMEOUT;
    endfunction

    task automatic idle_wait();
        repeat (HOLD + 6) tick();
        chk("busy_idle", int'(bus.busy), 0);
    endtask

    // One trig pulse of hi_len cycles; returns right after the echo falls (or after the rejection).
    task automatic run_meas(input int hi_len, input int d, input bit noise);
        int t0, br, bf, be;
        bus.dist_in = 8'(d);
        bus.trig = 1'b1;
        repeat (hi_len) tick();
        bus.trig = 1'b0;
        t0 = cyc + 1;
        br = n_rise; bf = n_fall; be = n_err;
        repeat (3) tick();
        bus.dist_in = 8'($urandom);
        if (hi_len >= TMIN) begin
            model_meas = (model_meas + 1) & 16'hFFFF;
            chk("busy_delay", int'(bus.busy), 1);
            for (int i = 0; i < BURST + TIMEOUT + 50 && n_fall == bf; i++) begin
                if (noise) bus.trig = ($urandom_range(0, 3) == 0);
                tick();
            end
            bus.trig = 1'b0;
            chk("echo_done", n_fall - bf, 1);
            chk("echo_rise", rise_cyc - t0, 2 + BURST);
            chk("echo_width", fall_cyc - rise_cyc, exp_width(d));
            chk("meas_cnt", int'(bus.meas_cnt), model_meas);
            chk("no_err", n_err - be, 0);
        end else begin
            repeat (4) tick();
            chk("err_count", n_err - be, 1);
            chk("err_time", err_cyc - t0, 2);
            chk("no_echo", n_rise - br, 0);
            chk("busy_rej", int'(bus.busy), 0);
            chk("meas_rej", int'(bus.meas_cnt), model_meas);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, be, br, dsel, hl;
        int dtab[5] = '{0, 1, 157, 158, 255};
        reset = 1'b1;
        bus.trig = 1'b0;
        bus.dist_in = 8'd0;
        repeat (3) tick();
        chk("rst_echo", int'(bus.echo), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_err", int'(bus.trig_err), 0);
        chk("rst_meas", int'(bus.meas_cnt), 0);
        reset = 1'b0;
        repeat (3) tick();

        run_meas(TMIN, 10, 0);      idle_wait();
        run_meas(TMIN - 1, 10, 0);  idle_wait();
        run_meas(TMIN + 4, 0, 0);   idle_wait();
        run_meas(TMIN + 4, 200, 0); idle_wait();
        run_meas(TMIN + 4, 157, 0); idle_wait();

        // Pulse inside HOLDOFF is ignored; a later one is accepted.
        run_meas(12, 20, 0);
        f = cyc; be = n_err; br = n_rise;
        repeat (20) tick();
        bus.trig = 1'b1;
        repeat (12) tick();
        bus.trig = 1'b0;
        repeat (6) tick();
        chk("hold_ign_err", n_err - be, 0);
        chk("hold_ign_rise", n_rise - br, 0);
        chk("hold_ign_meas", int'(bus.meas_cnt), model_meas);
        while (cyc < f + HOLD + 10) tick();
        run_meas(10, 33, 0); idle_wait();

        // trig held across HOLDOFF->IDLE is not a rise.
        run_meas(9, 5, 0);
        f = cyc; be = n_err; br = n_rise;
        repeat (50) tick();
        bus.trig = 1'b1;
        while (cyc < f + HOLD + 30) tick();
        bus.trig = 1'b0;
        repeat (10) tick();
        chk("held_rise", n_rise - br, 0);
        chk("held_err", n_err - be, 0);
        chk("held_meas", int'(bus.meas_cnt), model_meas);
        chk("held_busy", int'(bus.busy), 0);

        for (int k = 0; k < 14; k++) begin
            dsel = int'($urandom_range(0, 9));
            hl   = int'($urandom_range(TMIN - 3, TMIN + 12));
            run_meas(hl, (dsel < 5) ? dtab[dsel] : int'($urandom_range(1, 255)), bit'($urandom_range(0, 1)));
            idle_wait();
        end

        // Reset in the middle of an echo.
        br = n_rise;
        bus.dist_in = 8'd100;
        bus.trig = 1'b1;
        repeat (TMIN + 2) tick();
        bus.trig = 1'b0;
        for (int i = 0; i < BURST + 20 && n_rise == br; i++) tick();
        chk("rst_mid_rise", n_rise - br, 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_echo", int'(bus.echo), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_meas", int'(bus.meas_cnt), 0);
        reset = 1'b0;
        model_meas = 0;
        repeat (3) tick();
        run_meas(TMIN, 10, 0); idle_wait();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
